// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: funct3 codes, FSM states, captured-access metadata.
package mem_stage_pkg;

  localparam int XLEN    = 32;
  localparam int WSTRB_W = XLEN / 8;

  localparam logic [2:0] FUNCT3_BEQ = 3'b000;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Everything about an outstanding access that WB still needs once the ack arrives.
  typedef struct packed {
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_store;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] alu;
  } meta_t;

  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    logic taken;
    case (f3)
      FUNCT3_BEQ: taken = zero;
      FUNCT3_BNE: taken = ~zero;
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Byte-lane steering for data memory: store strobes/replicated data, load extraction/extension, alignment check.
// Purely combinational, zero latency, no flow control.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]         addr_lo,
  input  logic [2:0]         funct3,
  input  logic [XLEN-1:0]    store_data,
  input  logic [XLEN-1:0]    rdata,
  output logic [WSTRB_W-1:0] wstrb,
  output logic [XLEN-1:0]    wdata,
  output logic [XLEN-1:0]    load_data,
  output logic               misaligned
);

  logic [XLEN-1:0] lane;
  logic            is_unsigned;

  always_comb begin
    lane        = rdata >> {addr_lo, 3'b000};
    is_unsigned = funct3[2];
    wstrb       = {WSTRB_W{1'b1}};
    wdata       = store_data;
    load_data   = rdata;
    misaligned  = 1'b0;
    case (funct3[1:0])
      SZ_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{lane[7] & ~is_unsigned}}, lane[7:0]};
      end
      SZ_H: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{lane[15] & ~is_unsigned}}, lane[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        // Size code 11 has no narrower meaning, so it is handled as a word.
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: resolves branches, runs the dmem req/ack access, emits a one-entry WB result.
// Result 1 cycle after accept (non-memory) or after ack/timeout; ex_ready low while an access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [XLEN-1:0]    ALUResult,
  input  logic               zeroFlag,
  input  logic [XLEN-1:0]    branchTargetAddress,
  input  logic [XLEN-1:0]    storeData,
  input  logic [2:0]         funct3,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               Branch,
  input  logic               RegWrite,
  input  logic [4:0]         rd,
  output logic               PCSrc,
  output logic [XLEN-1:0]    pc_target,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic [WSTRB_W-1:0] dmem_wstrb,
  input  logic               dmem_ack,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               wb_valid,
  output logic               wb_RegWrite,
  output logic [4:0]         wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic               mem_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  meta_t              meta_q, meta_d;
  logic               ex_ready_q, ex_ready_d;
  logic               pcsrc_q, pcsrc_d;
  logic [XLEN-1:0]    pc_target_q, pc_target_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
  logic               wb_valid_q, wb_valid_d;
  logic               wb_regwrite_q, wb_regwrite_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic               mem_err_q, mem_err_d;

  logic               accept;
  logic               is_mem;
  logic [1:0]         al_addr;
  logic [2:0]         al_funct3;
  logic [WSTRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]    al_wdata;
  logic [XLEN-1:0]    al_load;
  logic               al_misaligned;

  // One aligner serves both phases: live EX fields on accept, captured fields while waiting for ack.
  assign al_addr   = (state_q == ST_WAIT) ? meta_q.addr_lo : ALUResult[1:0];
  assign al_funct3 = (state_q == ST_WAIT) ? meta_q.funct3  : funct3;

  load_store_align u_align (
    .addr_lo    (al_addr),
    .funct3     (al_funct3),
    .store_data (storeData),
    .rdata      (dmem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  assign accept = ex_valid & ex_ready_q;
  assign is_mem = MemRead | MemWrite;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    meta_d        = meta_q;
    pcsrc_d       = 1'b0;
    pc_target_d   = pc_target_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    mem_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wb_rd_d   = rd;
          wb_data_d = ALUResult;
          if (Branch) begin
            pcsrc_d     = branch_taken(funct3, zeroFlag);
            pc_target_d = branchTargetAddress;
            wb_valid_d  = 1'b1;
          end else if (is_mem && al_misaligned) begin
            wb_valid_d = 1'b1;
            mem_err_d  = 1'b1;
          end else if (is_mem) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {ALUResult[XLEN-1:2], 2'b00};
            wdata_d = al_wdata;
            wstrb_d = al_wstrb;
            meta_d  = '{funct3:    funct3,
                        rd:        rd,
                        reg_write: RegWrite,
                        is_store:  MemWrite,
                        addr_lo:   ALUResult[1:0],
                        alu:       ALUResult};
          end else begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = RegWrite;
          end
        end
      end
      ST_WAIT: begin
        // An ack arriving on the timeout edge completes normally.
        if (dmem_ack) begin
          state_d       = ST_IDLE;
          req_d         = 1'b0;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = meta_q.reg_write & ~meta_q.is_store;
          wb_rd_d       = meta_q.rd;
          wb_data_d     = meta_q.is_store ? meta_q.alu : al_load;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = meta_q.rd;
          wb_data_d  = meta_q.alu;
          mem_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ex_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      meta_q        <= '0;
      ex_ready_q    <= 1'b0;
      pcsrc_q       <= 1'b0;
      pc_target_q   <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      meta_q        <= meta_d;
      ex_ready_q    <= ex_ready_d;
      pcsrc_q       <= pcsrc_d;
      pc_target_q   <= pc_target_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign ex_ready    = ex_ready_q;
  assign PCSrc       = pcsrc_q;
  assign pc_target   = pc_target_q;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_wstrb  = wstrb_q;
  assign wb_valid    = wb_valid_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: driver pushes expectations, memory responder and WB monitor check.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] ALUResult, branchTargetAddress, storeData;
  logic        zeroFlag;
  logic [2:0]  funct3;
  logic        MemRead, MemWrite, Branch, RegWrite;
  logic [4:0]  rd;
  logic        PCSrc;
  logic [31:0] pc_target;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_RegWrite, mem_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALUResult(ALUResult), .zeroFlag(zeroFlag), .branchTargetAddress(branchTargetAddress),
    .storeData(storeData), .funct3(funct3), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .RegWrite(RegWrite), .rd(rd), .PCSrc(PCSrc), .pc_target(pc_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_err(mem_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        regwrite;
    logic [31:0] data;
    logic        check_data;
    logic        err;
    logic        pcsrc;
    logic [31:0] target;
  } wb_exp_t;

  // mode: 0 = ack after delay, 1 = never ack (timeout), 2 = aborted by reset then late ack
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          mode;
    int          delay;
    logic [31:0] rdata;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference view of a load: pick the addressed lane, then zero/sign extend by arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input int size, input logic uns);
    logic [31:0] lane, v;
    lane = rdata >> (8 * (addr % 4));
    if (size == 0) begin
      v = lane % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = lane % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic issue(input logic [31:0] alu, input logic z, input logic [31:0] bta,
                       input logic [31:0] sd, input logic [2:0] f3, input logic mr, input logic mw,
                       input logic br, input logic rw, input logic [4:0] rdv,
                       input int mode, input int delay, input logic [31:0] rdata);
    wb_exp_t  w;
    mem_exp_t m;
    int size, guard;
    logic mis, waits;
    size = int'(f3[1:0]);
    mis  = (size == 1 && alu % 2 != 0) || (size == 2 && alu % 4 != 0);
    ALUResult = alu; zeroFlag = z; branchTargetAddress = bta; storeData = sd; funct3 = f3;
    MemRead = mr; MemWrite = mw; Branch = br; RegWrite = rw; rd = rdv; ex_valid = 1'b1;
    guard = 0;
    while (ex_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("accept_timeout", {31'b0, ex_ready}, 32'd1);
      ex_valid = 1'b0;
      return;
    end
    w = '{rd: rdv, regwrite: 1'b0, data: alu, check_data: 1'b1, err: 1'b0, pcsrc: 1'b0, target: bta};
    waits = 1'b0;
    if (br) begin
      w.pcsrc = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
    end else if ((mr || mw) && mis) begin
      w.err = 1'b1;
      w.check_data = 1'b0;
    end else if (mr || mw) begin
      waits = 1'b1;
      m.addr  = alu - (alu % 4);
      m.we    = mw;
      m.strb  = (size == 0) ? 4'(1 << (alu % 4)) : (size == 1) ? 4'(3 << (alu % 4)) : 4'hF;
      m.wdata = (size == 0) ? (sd % 256) * 32'h0101_0101 :
                (size == 1) ? (sd % 65536) * 32'h0001_0001 : sd;
      m.mode  = mode;
      m.delay = delay;
      m.rdata = rdata;
      mem_q.push_back(m);
      if (mode == 1) begin
        w.err = 1'b1;
        w.check_data = 1'b0;
      end else if (mw) begin
        w.check_data = 1'b0;
      end else begin
        w.regwrite = rw;
        w.data = model_load(rdata, alu, size, f3[2]);
      end
    end else begin
      w.regwrite = rw;
    end
    wb_q.push_back(w);
    @(negedge clk);
    ex_valid = 1'b0;
    if (waits) begin
      check("ex_ready_low_after_mem_accept", {31'b0, ex_ready}, 32'd0);
      check("req_after_mem_accept", {31'b0, dmem_req}, 32'd1);
    end else begin
      check("wb_valid_next_cycle", {31'b0, wb_valid}, 32'd1);
      check("no_req_for_non_access", {31'b0, dmem_req}, 32'd0);
    end
  endtask

  // Memory responder: checks each request against the expectation, then acks per its mode.
  initial begin
    mem_exp_t e;
    int cnt;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (dmem_req === 1'b1 && reset === 1'b0) begin
        if (mem_q.size() == 0) begin
          check("unexpected_dmem_req", {31'b0, dmem_req}, 32'd0);
        end else begin
          e = mem_q.pop_front();
          check("dmem_addr", dmem_addr, e.addr);
          check("dmem_we", {31'b0, dmem_we}, {31'b0, e.we});
          if (e.we) begin
            check("dmem_wstrb", {28'b0, dmem_wstrb}, {28'b0, e.strb});
            check("dmem_wdata", dmem_wdata, e.wdata);
          end
          if (e.mode == 0) begin
            repeat (e.delay) begin
              check("ex_ready_during_wait", {31'b0, ex_ready}, 32'd0);
              @(negedge clk);
            end
            dmem_ack = 1'b1;
            dmem_rdata = e.rdata;
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            check("req_drops_after_ack", {31'b0, dmem_req}, 32'd0);
          end else begin
            cnt = 1;
            while (dmem_req === 1'b1 && cnt < 100) begin
              @(negedge clk);
              if (dmem_req === 1'b1) cnt++;
            end
            if (e.mode == 1) check("timeout_req_cycles", cnt, 32'd16);
            if (e.mode == 2) begin
              dmem_ack = 1'b1;
              dmem_rdata = e.rdata;
              repeat (3) @(negedge clk);
              dmem_ack = 1'b0;
            end
          end
        end
      end
    end
  end

  // WB monitor: every result pulse pops one expectation; branch/error pulses never appear alone.
  initial begin
    wb_exp_t w;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (wb_valid === 1'b1) begin
          if (wb_q.size() == 0) begin
            check("unexpected_wb_valid", {31'b0, wb_valid}, 32'd0);
          end else begin
            w = wb_q.pop_front();
            check("wb_rd", {27'b0, wb_rd}, {27'b0, w.rd});
            check("wb_RegWrite", {31'b0, wb_RegWrite}, {31'b0, w.regwrite});
            check("mem_err", {31'b0, mem_err}, {31'b0, w.err});
            check("PCSrc", {31'b0, PCSrc}, {31'b0, w.pcsrc});
            if (w.pcsrc) check("pc_target", pc_target, w.target);
            if (w.check_data) check("wb_data", wb_data, w.data);
          end
        end else begin
          if (PCSrc !== 1'b0) check("PCSrc_without_result", {31'b0, PCSrc}, 32'd0);
          if (mem_err !== 1'b0) check("mem_err_without_result", {31'b0, mem_err}, 32'd0);
        end
      end
    end
  end

  initial begin
    int guard, kind, size;
    logic [31:0] a;
    logic [2:0]  f3;
    reset = 1'b1;
    ex_valid = 1'b0;
    ALUResult = 0; zeroFlag = 0; branchTargetAddress = 0; storeData = 0; funct3 = 0;
    MemRead = 0; MemWrite = 0; Branch = 0; RegWrite = 0; rd = 0;
    repeat (3) @(negedge clk);
    check("reset_ex_ready", {31'b0, ex_ready}, 32'd0);
    check("reset_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("reset_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ex_ready_after_reset", {31'b0, ex_ready}, 32'd1);

    issue(32'h0000_002A, 0, 0, 0, 3'b000, 0, 0, 0, 1, 5'd5, 0, 0, 0);
    issue(32'h0, 1, 32'h0000_0100, 0, 3'b000, 0, 0, 1, 0, 5'd0, 0, 0, 0);
    issue(32'h0, 1, 32'h0000_0200, 0, 3'b001, 0, 0, 1, 0, 5'd0, 0, 0, 0);
    issue(32'h0000_1003, 0, 0, 0, 3'b000, 1, 0, 0, 1, 5'd7, 0, 3, 32'h80FF_0000);
    issue(32'h0000_1003, 0, 0, 0, 3'b100, 1, 0, 0, 1, 5'd8, 0, 3, 32'h80FF_0000);
    issue(32'h0000_2002, 0, 0, 32'h0000_BEEF, 3'b001, 0, 1, 0, 1, 5'd9, 0, 1, 0);
    issue(32'h0000_3001, 0, 0, 0, 3'b010, 1, 0, 0, 1, 5'd10, 0, 0, 0);
    issue(32'h0000_3000, 0, 0, 0, 3'b010, 1, 0, 0, 1, 5'd11, 1, 0, 0);
    issue(32'h0000_3004, 0, 0, 0, 3'b010, 1, 0, 0, 1, 5'd12, 0, 15, 32'h1234_5678);

    // Reset in the middle of an access, with the ack showing up afterwards.
    issue(32'h0000_4000, 0, 0, 0, 3'b010, 1, 0, 0, 1, 5'd13, 2, 0, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wb_q.delete();
    @(negedge clk);
    check("reset_mid_wait_req", {31'b0, dmem_req}, 32'd0);
    check("reset_mid_wait_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset_mid_wait_ex_ready", {31'b0, ex_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ex_ready_after_mid_reset", {31'b0, ex_ready}, 32'd1);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 4);
      size = $urandom_range(0, 2);
      a = $urandom;
      if (kind == 2 || kind == 3) a = a - (a % (1 << size));
      f3 = {1'b0, 2'(size)};
      case (kind)
        0: issue($urandom, $urandom_range(0, 1), $urandom, $urandom, 3'($urandom_range(0, 7)),
                 0, 0, 0, 1'($urandom_range(0, 1)), 5'($urandom), 0, 0, 0);
        1: issue($urandom, $urandom_range(0, 1), $urandom, $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)),
                 5'($urandom), 0, 0, 0);
        2, 4: begin
          if (size < 2) f3[2] = 1'($urandom_range(0, 1));
          if (kind == 4 && $urandom_range(0, 1) == 1)
            issue(a, 0, 0, $urandom, f3, 0, 1, 0, 1, 5'($urandom),
                  ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 15), 0);
          else
            issue(a, 0, 0, 0, f3, 1, 0, 0, 1'($urandom_range(0, 1)), 5'($urandom),
                  ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 15), $urandom);
        end
        default: issue(a, 0, 0, $urandom, f3, 0, 1, 0, 1'($urandom_range(0, 1)), 5'($urandom),
                       0, $urandom_range(0, 15), 0);
      endcase
    end

    guard = 0;
    while ((wb_q.size() != 0 || mem_q.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_wb_queue", wb_q.size(), 32'd0);
    check("drain_mem_queue", mem_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
